inflight_instr_tracker: RTL and testbench

INFLIGHT_INSTR_TRACKER -- requirements
Module: inflight_instr_tracker

---
 rtl/inflight_instr_tracker_pkg.sv | 16 +
 rtl/inflight_wf_counter.sv | 61 ++++++
 rtl/inflight_instr_tracker.sv | 96 +++++++++
 tb/tb_inflight_instr_tracker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/inflight_instr_tracker_pkg.sv
// Shared defaults for the in-flight instruction tracker slice.
// Modules take these as parameter defaults so one edit retargets the whole block.
package inflight_instr_tracker_pkg;

   localparam int DEF_NUM_WF       = 40;
   localparam int DEF_WF_ID_W      = 6;
   localparam int DEF_CNT_W        = 4;
   localparam int DEF_MAX_INFLIGHT = 15;
   localparam int DEF_NUM_RETIRE   = 3;

   // Width needed to hold a per-cycle retire count of 0..num_retire.
   function automatic int dec_width(input int num_retire);
      return (num_retire < 1) ? 1 : $clog2(num_retire + 1);
   endfunction

endpackage

// File: rtl/inflight_wf_counter.sv
// One wavefront's in-flight counter: saturating update, flush and error pulses.
// nxt_cnt is exported so the top can register a total that tracks the counters exactly.
module inflight_wf_counter
   import inflight_instr_tracker_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
   parameter int DEC_W        = dec_width(DEF_NUM_RETIRE)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic [DEC_W-1:0] dec,
   input  logic             flush,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] nxt_cnt,
   output logic             ovf_pulse,
   output logic             unf_pulse
);

   localparam logic signed [CNT_W+1:0] MAX_S = (CNT_W+2)'(MAX_INFLIGHT);

   logic                    active;
   logic signed [CNT_W+1:0] sum;
   logic                    over;
   logic                    under;

   assign active = inc | (dec != '0) | flush;
   assign sum    = {2'b00, cnt} + (CNT_W+2)'(inc) - (CNT_W+2)'(dec);
   assign over   = (sum > MAX_S);
   assign under  = sum[CNT_W+1];

   // Flush wins over everything and never reports an error.
   always_comb begin
      nxt_cnt   = cnt;
      ovf_pulse = 1'b0;
      unf_pulse = 1'b0;
      if (flush) begin
         nxt_cnt = '0;
      end else if (active) begin
         if (over) begin
            nxt_cnt   = CNT_W'(MAX_INFLIGHT);
            ovf_pulse = 1'b1;
         end else if (under) begin
            nxt_cnt   = '0;
            unf_pulse = 1'b1;
         end else begin
            nxt_cnt = sum[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (active) begin
         cnt <= nxt_cnt;
      end
   end

endmodule

// File: rtl/inflight_instr_tracker.sv
// Tracks issued-but-not-retired instructions per wavefront slot, flags empty/full
// slots, keeps a registered grand total and sticky over/underflow errors.
module inflight_instr_tracker
   import inflight_instr_tracker_pkg::*;
#(
   parameter int NUM_WF       = DEF_NUM_WF,
   parameter int WF_ID_W      = DEF_WF_ID_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
   parameter int NUM_RETIRE   = DEF_NUM_RETIRE,
   localparam int TOT_W       = $clog2(NUM_WF*MAX_INFLIGHT+1)
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          issued_en,
   input  logic [WF_ID_W-1:0]            issued_wfid,
   input  logic [NUM_RETIRE-1:0]         retire_en,
   input  logic [NUM_RETIRE*WF_ID_W-1:0] retire_wfid,
   input  logic                          flush_en,
   input  logic [WF_ID_W-1:0]            flush_wfid,
   input  logic                          err_clr,
   output logic [NUM_WF-1:0]             no_inflight_flag,
   output logic [NUM_WF-1:0]             max_inflight_flag,
   output logic [TOT_W-1:0]              total_inflight,
   output logic                          err_overflow,
   output logic                          err_underflow
);

   localparam int DEC_W = dec_width(NUM_RETIRE);

   logic [CNT_W-1:0]  cnt     [NUM_WF];
   logic [CNT_W-1:0]  nxt_cnt [NUM_WF];
   logic [NUM_WF-1:0] ovf_pulse;
   logic [NUM_WF-1:0] unf_pulse;
   logic [TOT_W-1:0]  total_nxt;

   // Ids >= NUM_WF match no slot, so out-of-range events fall away naturally.
   for (genvar w = 0; w < NUM_WF; w++) begin : g_slot
      logic             inc;
      logic             flush;
      logic [DEC_W-1:0] dec;

      always_comb begin
         inc   = issued_en && (issued_wfid == WF_ID_W'(w));
         flush = flush_en && (flush_wfid == WF_ID_W'(w));
         dec   = '0;
         for (int k = 0; k < NUM_RETIRE; k++) begin
            if (retire_en[k] && (retire_wfid[k*WF_ID_W +: WF_ID_W] == WF_ID_W'(w))) begin
               dec = dec + DEC_W'(1);
            end
         end
      end

      inflight_wf_counter #(
         .CNT_W        (CNT_W),
         .MAX_INFLIGHT (MAX_INFLIGHT),
         .DEC_W        (DEC_W)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc),
         .dec       (dec),
         .flush     (flush),
         .cnt       (cnt[w]),
         .nxt_cnt   (nxt_cnt[w]),
         .ovf_pulse (ovf_pulse[w]),
         .unf_pulse (unf_pulse[w])
      );

      assign no_inflight_flag[w]  = (cnt[w] == '0);
      assign max_inflight_flag[w] = (cnt[w] == CNT_W'(MAX_INFLIGHT));
   end

   always_comb begin
      total_nxt = '0;
      for (int w = 0; w < NUM_WF; w++) begin
         total_nxt = total_nxt + TOT_W'(nxt_cnt[w]);
      end
   end

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         total_inflight <= '0;
         err_overflow   <= 1'b0;
         err_underflow  <= 1'b0;
      end else begin
         total_inflight <= total_nxt;
         if (|ovf_pulse)   err_overflow  <= 1'b1;
         else if (err_clr) err_overflow  <= 1'b0;
         if (|unf_pulse)   err_underflow <= 1'b1;
         else if (err_clr) err_underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inflight_instr_tracker.sv
// Bench for inflight_instr_tracker: directed scenarios plus random traffic,
// all checked against a per-wavefront integer model of the counting rules.
module tb_inflight_instr_tracker;

   localparam int NW  = 40;
   localparam int IDW = 6;
   localparam int MX  = 15;
   localparam int NR  = 3;
   localparam int TW  = $clog2(NW*MX+1);

   logic               clk;
   logic               rst_n;
   logic               issued_en;
   logic [IDW-1:0]     issued_wfid;
   logic [NR-1:0]      retire_en;
   logic [NR*IDW-1:0]  retire_wfid;
   logic               flush_en;
   logic [IDW-1:0]     flush_wfid;
   logic               err_clr;
   logic [NW-1:0]      no_inflight_flag;
   logic [NW-1:0]      max_inflight_flag;
   logic [TW-1:0]      total_inflight;
   logic               err_overflow;
   logic               err_underflow;

   int n_cmp;
   int n_bad;

   int m_cnt [NW];
   int m_ov;
   int m_un;

   inflight_instr_tracker dut (
      .clk               (clk),
      .rst               (rst_n),
      .issued_en         (issued_en),
      .issued_wfid       (issued_wfid),
      .retire_en         (retire_en),
      .retire_wfid       (retire_wfid),
      .flush_en          (flush_en),
      .flush_wfid        (flush_wfid),
      .err_clr           (err_clr),
      .no_inflight_flag  (no_inflight_flag),
      .max_inflight_flag (max_inflight_flag),
      .total_inflight    (total_inflight),
      .err_overflow      (err_overflow),
      .err_underflow     (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NW-1:0] exp_no();
      logic [NW-1:0] v;
      for (int w = 0; w < NW; w++) v[w] = (m_cnt[w] == 0);
      return v;
   endfunction

   function automatic logic [NW-1:0] exp_max();
      logic [NW-1:0] v;
      for (int w = 0; w < NW; w++) v[w] = (m_cnt[w] == MX);
      return v;
   endfunction

   function automatic int exp_total();
      int s;
      s = 0;
      for (int w = 0; w < NW; w++) s += m_cnt[w];
      return s;
   endfunction

   task automatic model_reset();
      for (int w = 0; w < NW; w++) m_cnt[w] = 0;
      m_ov = 0;
      m_un = 0;
   endtask

   // Drive one cycle at the falling edge, advance the model, settle after the rising edge.
   task automatic drive(input logic ien, input logic [IDW-1:0] iid,
                        input logic [NR-1:0] ren, input logic [NR*IDW-1:0] rid,
                        input logic fen, input logic [IDW-1:0] fid, input logic clr);
      int v, d, inc, any_ov, any_un;
      @(negedge clk);
      issued_en = ien; issued_wfid = iid;
      retire_en = ren; retire_wfid = rid;
      flush_en = fen; flush_wfid = fid; err_clr = clr;
      any_ov = 0; any_un = 0;
      for (int w = 0; w < NW; w++) begin
         d = 0;
         for (int k = 0; k < NR; k++)
            if (ren[k] && (int'(rid[k*IDW +: IDW]) == w)) d++;
         inc = (ien && int'(iid) == w) ? 1 : 0;
         if (fen && int'(fid) == w) begin
            m_cnt[w] = 0;
         end else if (inc != 0 || d != 0) begin
            v = m_cnt[w] + inc - d;
            if (v > MX) begin v = MX; any_ov = 1; end
            else if (v < 0) begin v = 0; any_un = 1; end
            m_cnt[w] = v;
         end
      end
      if (any_ov != 0) m_ov = 1; else if (clr) m_ov = 0;
      if (any_un != 0) m_un = 1; else if (clr) m_un = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic issue(input int id, input int n);
      for (int i = 0; i < n; i++) drive(1'b1, IDW'(id), '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      issued_en = 0; issued_wfid = '0; retire_en = '0; retire_wfid = '0;
      flush_en = 0; flush_wfid = '0; err_clr = 0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (no_inflight_flag !== {NW{1'b1}}) begin n_bad++; $display("FAIL reset_no got=%h exp=all-ones", no_inflight_flag); end
      n_cmp++; if (max_inflight_flag !== '0) begin n_bad++; $display("FAIL reset_max got=%h exp=0", max_inflight_flag); end
      n_cmp++; if (total_inflight !== '0) begin n_bad++; $display("FAIL reset_total got=%0d exp=0", total_inflight); end
      n_cmp++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b%b exp=00", err_overflow, err_underflow); end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      n_cmp++; if (total_inflight !== '0 || no_inflight_flag !== {NW{1'b1}}) begin n_bad++; $display("FAIL reset_idle total=%0d no=%h exp=0/all-ones", total_inflight, no_inflight_flag); end
   endtask

   task automatic test_overflow();
      issue(5, 14);
      n_cmp++; if (max_inflight_flag[5] !== 1'b0 || total_inflight !== 14) begin n_bad++; $display("FAIL ovf_14 max5=%b total=%0d exp=0/14", max_inflight_flag[5], total_inflight); end
      issue(5, 1);
      n_cmp++; if (max_inflight_flag !== (NW'(1) << 5) || total_inflight !== 15 || err_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_15 max=%h total=%0d ov=%b exp=bit5/15/0", max_inflight_flag, total_inflight, err_overflow); end
      issue(5, 1);
      n_cmp++; if (max_inflight_flag[5] !== 1'b1 || total_inflight !== 15 || err_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_16 max5=%b total=%0d ov=%b exp=1/15/1", max_inflight_flag[5], total_inflight, err_overflow); end
   endtask

   task automatic test_multi_retire();
      drive(1'b0, '0, '0, '0, 1'b1, IDW'(5), 1'b1);
      n_cmp++; if (total_inflight !== 0 || err_overflow !== 1'b0 || no_inflight_flag[5] !== 1'b1) begin n_bad++; $display("FAIL flush_clr total=%0d ov=%b no5=%b exp=0/0/1", total_inflight, err_overflow, no_inflight_flag[5]); end
      issue(5, 3);
      drive(1'b1, IDW'(5), 3'b111, {IDW'(5), IDW'(5), IDW'(5)}, 1'b0, '0, 1'b0);
      n_cmp++; if (total_inflight !== 1 || no_inflight_flag[5] !== 1'b0 || err_underflow !== 1'b0) begin n_bad++; $display("FAIL multi_retire total=%0d no5=%b un=%b exp=1/0/0", total_inflight, no_inflight_flag[5], err_underflow); end
      drive(1'b0, '0, 3'b001, {12'd0, IDW'(5)}, 1'b0, '0, 1'b0);
   endtask

   task automatic test_net_zero();
      drive(1'b1, IDW'(7), 3'b010, {6'd0, IDW'(7), 6'd0}, 1'b0, '0, 1'b0);
      n_cmp++; if (no_inflight_flag[7] !== 1'b1 || err_underflow !== 1'b0 || err_overflow !== 1'b0 || total_inflight !== 0) begin n_bad++; $display("FAIL net_zero no7=%b un=%b ov=%b total=%0d exp=1/0/0/0", no_inflight_flag[7], err_underflow, err_overflow, total_inflight); end
      drive(1'b0, '0, 3'b100, {IDW'(7), 12'd0}, 1'b0, '0, 1'b0);
      n_cmp++; if (err_underflow !== 1'b1 || total_inflight !== 0) begin n_bad++; $display("FAIL underflow un=%b total=%0d exp=1/0", err_underflow, total_inflight); end
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL err_clr un=%b exp=0", err_underflow); end
      // Set wins over a simultaneous clear.
      drive(1'b0, '0, 3'b001, {12'd0, IDW'(7)}, 1'b0, '0, 1'b1);
      n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL set_wins un=%b exp=1", err_underflow); end
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_flush();
      issue(9, 6);
      issue(3, 2);
      n_cmp++; if (total_inflight !== 8) begin n_bad++; $display("FAIL flush_pre total=%0d exp=8", total_inflight); end
      drive(1'b1, IDW'(9), 3'b001, {12'd0, IDW'(9)}, 1'b1, IDW'(9), 1'b0);
      n_cmp++; if (total_inflight !== 2 || no_inflight_flag[9] !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_bad++; $display("FAIL flush total=%0d no9=%b ov=%b un=%b exp=2/1/0/0", total_inflight, no_inflight_flag[9], err_overflow, err_underflow); end
   endtask

   task automatic test_out_of_range();
      drive(1'b1, IDW'(45), 3'b011, {6'd0, IDW'(63), IDW'(40)}, 1'b1, IDW'(3), 1'b0);
      n_cmp++; if (total_inflight !== 0 || err_overflow !== 1'b0 || err_underflow !== 1'b0 || no_inflight_flag !== {NW{1'b1}}) begin n_bad++; $display("FAIL out_of_range total=%0d ov=%b un=%b no=%h exp=0/0/0/all-ones", total_inflight, err_overflow, err_underflow, no_inflight_flag); end
   endtask

   function automatic logic [IDW-1:0] rand_id();
      return ($urandom_range(0, 9) == 0) ? IDW'($urandom_range(0, 63)) : IDW'($urandom_range(0, 5));
   endfunction

   task automatic test_random();
      logic [NR*IDW-1:0] rid;
      for (int c = 0; c < 400; c++) begin
         rid = {rand_id(), rand_id(), rand_id()};
         drive(1'($urandom_range(0, 3) != 0), rand_id(), NR'($urandom_range(0, 7)) & NR'($urandom_range(0, 7)), rid,
               1'($urandom_range(0, 15) == 0), rand_id(), 1'($urandom_range(0, 7) == 0));
         n_cmp++; if (no_inflight_flag !== exp_no()) begin n_bad++; $display("FAIL rnd_no cyc=%0d got=%h exp=%h", c, no_inflight_flag, exp_no()); end
         n_cmp++; if (max_inflight_flag !== exp_max()) begin n_bad++; $display("FAIL rnd_max cyc=%0d got=%h exp=%h", c, max_inflight_flag, exp_max()); end
         n_cmp++; if (int'(total_inflight) != exp_total()) begin n_bad++; $display("FAIL rnd_total cyc=%0d got=%0d exp=%0d", c, total_inflight, exp_total()); end
         n_cmp++; if (err_overflow !== 1'(m_ov) || err_underflow !== 1'(m_un)) begin n_bad++; $display("FAIL rnd_err cyc=%0d got=%b%b exp=%0d%0d", c, err_overflow, err_underflow, m_ov, m_un); end
      end
   endtask

   task automatic test_async_reset();
      issue(1, 4);
      issue(2, 15);
      issue(2, 1);
      issue(30, 3);
      n_cmp++; if (int'(total_inflight) != exp_total() || err_overflow !== 1'b1) begin n_bad++; $display("FAIL areset_pre total=%0d ov=%b exp=%0d/1", total_inflight, err_overflow, exp_total()); end
      issued_en = 1'b1; issued_wfid = IDW'(1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (total_inflight !== '0 || no_inflight_flag !== {NW{1'b1}} || max_inflight_flag !== '0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_bad++; $display("FAIL areset total=%0d no=%h max=%h ov=%b un=%b exp=reset values", total_inflight, no_inflight_flag, max_inflight_flag, err_overflow, err_underflow); end
      @(negedge clk);
      issued_en = 1'b0;
      rst_n = 1'b1;
      idle();
      n_cmp++; if (total_inflight !== '0 || no_inflight_flag !== {NW{1'b1}}) begin n_bad++; $display("FAIL areset_post total=%0d no=%h exp=0/all-ones", total_inflight, no_inflight_flag); end
      issue(1, 1);
      n_cmp++; if (total_inflight !== 1 || no_inflight_flag[1] !== 1'b0) begin n_bad++; $display("FAIL areset_first total=%0d no1=%b exp=1/0", total_inflight, no_inflight_flag[1]); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_overflow();
      test_multi_retire();
      test_net_zero();
      test_flush();
      test_out_of_range();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
